trans_phase_driver: RTL and testbench
=====================================

TRANS_PHASE_DRIVER -- requirements
Module: trans_phase_driver

Interface
REQ-001 Parameter NUM_CH, default 49: number of transducer channels driven.
REQ-002 Parameter PERIOD, default 1250: 40 kHz drive period in CLK cycles at 50 MHz.
REQ-003 Parameter DUTY, default 625: high cycles per period (50 %).
REQ-004 CLK  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-005 RST_N  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-006 out_en  input  1  drive enable; 0 forces all trans outputs low.
REQ-007 ld_valid  input  1  phase-load request.
REQ-008 ld_ready  output  1  phase-load accept.
REQ-009 ld_ch  input  6  target channel index, 0..NUM_CH-1.
REQ-010 ld_phase  input  11  phase delay in CLK cycles.
REQ-011 ld_err  output  1  sticky flag: illegal channel index seen.
REQ-012 trans  output  NUM_CH  per-channel 40 kHz drive, bit i to transducer i+1.
REQ-013 period_strobe  output  1  one-cycle pulse on last cycle of each period.

Function
REQ-014 11-bit base counter runs 0..PERIOD-1 and wraps to 0; period_strobe is high exactly when base == PERIOD-1.
REQ-015 Each channel holds a shadow phase and an active phase register, 11 bits each.
REQ-016 ld_ready is 1 in every cycle except base == PERIOD-1 (commit cycle), when it is 0.
REQ-017 A transfer occurs on a rising edge with ld_valid and ld_ready both 1; ld_valid without ld_ready holds ld_ch/ld_phase stable until accepted.
REQ-018 On transfer with ld_ch < NUM_CH: shadow[ld_ch] <= ld_phase, saturated to PERIOD-1 when ld_phase >= PERIOD.
REQ-019 On transfer with ld_ch >= NUM_CH: no shadow write, ld_err <= 1; ld_err clears only on reset.
REQ-020 On commit cycle edge all active[i] <= shadow[i] simultaneously; new phases take effect from base == 0 of the next period, never mid-period.
REQ-021 Per-channel offset = (base + PERIOD - active[i]) mod PERIOD, computed in 12 bits with single conditional subtract.
REQ-022 trans[i] is registered: trans[i] <= out_en AND (offset < DUTY); latency one cycle from base value to output.
REQ-023 out_en deassert forces trans to 0 on the next edge; reassert resumes drive on next edge with current base alignment (no period restart).
REQ-024 Repeated writes to one channel before commit: last accepted value wins.

Reset
REQ-025 While RST_N = 0: base = 0, all shadow and active = 0, trans = 0, period_strobe = 0, ld_err = 0, ld_ready = 1.
REQ-026 Reset asserted mid-period or mid-load discards pending shadow writes; after release base starts at 0 on first edge.

Configuration
REQ-027 Macro TRANS_SCAN_EN: when defined, adds inputs scan_mode (1 bit) and outputs scan_ch (6 bits); scan_mode = 1 drives only channel scan_ch (others 0), scan_ch advancing by 1 every 40000 periods (1 s) and wrapping NUM_CH-1 -> 0, resetting to 0 on scan_mode rising or RST_N low.
REQ-028 Without TRANS_SCAN_EN: ports scan_mode/scan_ch absent, all channels driven per REQ-022.

Verification
REQ-029 Reset, out_en = 1, no loads -> all trans identical, high 625 cycles, low 625 cycles, period_strobe every 1250 cycles.
REQ-030 Load ch 3 phase 100 mid-period -> no change until next period; then trans[3] rises 100 cycles after trans[0].
REQ-031 ld_valid held during commit cycle -> ld_ready 0 that cycle, accepted next cycle, value applies one period later.
REQ-032 Load ld_ch = 60 -> ld_err = 1, no trans change; ld_phase = 2000 on ch 5 -> trans[5] lag 1249 cycles.
REQ-033 Assert RST_N low mid-period after loads -> trans 0 immediately, all phases 0 after release.
REQ-034 With TRANS_SCAN_EN, scan_mode = 1 -> only trans[0] active for 40000 periods, then only trans[1].

Source files
------------

// File: rtl/trans_phase_driver.sv
// Phase-shifted 40 kHz transducer driver, double-buffered per-channel phases.
// Define TRANS_SCAN_EN to add the single-channel scan mode (scan_mode/scan_ch).
module trans_phase_driver #(
   parameter int NUM_CH = 49,
   parameter int PERIOD = 1250,
   parameter int DUTY   = 625
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              out_en,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [5:0]        ld_ch,
   input  logic [10:0]       ld_phase,
   output logic              ld_err,
`ifdef TRANS_SCAN_EN
   input  logic              scan_mode,
   output logic [5:0]        scan_ch,
`endif
   output logic [NUM_CH-1:0] trans,
   output logic              period_strobe
);

   localparam logic [10:0] LAST   = 11'(PERIOD - 1);
   localparam logic [11:0] PER12  = 12'(PERIOD);
   localparam logic [11:0] DUTY12 = 12'(DUTY);

   logic [10:0]       base;
   logic              commit;
   logic              xfer;
   logic              ch_ok;
   logic [10:0]       ph_sat;
   logic [10:0]       shadow [NUM_CH];
   logic [10:0]       active [NUM_CH];
   logic [11:0]       sum    [NUM_CH];
   logic [11:0]       off    [NUM_CH];
   logic [NUM_CH-1:0] ch_mask;
   logic [NUM_CH-1:0] trans_d;

   assign commit        = (base == LAST);
   assign period_strobe = commit;
   assign ld_ready      = ~commit;
   assign xfer          = ld_valid & ld_ready;
   assign ch_ok         = (int'(ld_ch) < NUM_CH);
   assign ph_sat        = (ld_phase >= 11'(PERIOD)) ? LAST : ld_phase;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         base <= '0;
      end else if (commit) begin
         base <= '0;
      end else begin
         base <= base + 11'd1;
      end
   end

   // Loads only touch shadow; active changes only at the period boundary.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
      end else if (commit) begin
         for (int i = 0; i < NUM_CH; i++) begin
            active[i] <= shadow[i];
         end
      end else if (xfer && ch_ok) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (ld_ch == 6'(i)) begin
               shadow[i] <= ph_sat;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ld_err <= 1'b0;
      end else if (xfer && !ch_ok) begin
         ld_err <= 1'b1;
      end
   end

`ifdef TRANS_SCAN_EN
   localparam int SCAN_PERIODS = 40000;

   logic [15:0] per_cnt;
   logic        scan_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         per_cnt <= '0;
         scan_ch <= '0;
         scan_q  <= 1'b0;
      end else begin
         scan_q <= scan_mode;
         if (scan_mode && !scan_q) begin
            per_cnt <= '0;
            scan_ch <= '0;
         end else if (commit) begin
            if (per_cnt == 16'(SCAN_PERIODS - 1)) begin
               per_cnt <= '0;
               scan_ch <= (scan_ch == 6'(NUM_CH - 1)) ?
                          6'd0 : scan_ch + 6'd1;
            end else begin
               per_cnt <= per_cnt + 16'd1;
            end
         end
      end
   end

   always_comb begin
      ch_mask = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_mask[i] = !scan_mode || (scan_ch == 6'(i));
      end
   end
`else
   assign ch_mask = '1;
`endif

   // base + PERIOD - phase lies in 1..2*PERIOD-1, so one subtract wraps it.
   always_comb begin
      trans_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sum[i] = {1'b0, base} + PER12 - {1'b0, active[i]};
         off[i] = (sum[i] >= PER12) ? sum[i] - PER12 : sum[i];
         trans_d[i] = out_en & (off[i] < DUTY12) & ch_mask[i];
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         trans <= '0;
      end else begin
         trans <= trans_d;
      end
   end

endmodule

// File: tb/tb_trans_phase_driver.sv
// Scoreboard bench for trans_phase_driver: random loads vs. a phase model.
// Expected outputs are queued per edge and checked by a separate monitor.
module tb_trans_phase_driver;

   localparam int NUM_CH = 49;
   localparam int PERIOD = 1250;
   localparam int DUTY   = 625;

   typedef struct packed {
      logic [NUM_CH-1:0] trans;
      logic              strobe;
      logic              ready;
      logic              err;
   } exp_t;

   logic              CLK = 1'b0;
   logic              RST_N = 1'b0;
   logic              out_en = 1'b0;
   logic              ld_valid = 1'b0;
   logic [5:0]        ld_ch = '0;
   logic [10:0]       ld_phase = '0;
   logic              ld_ready;
   logic              ld_err;
   logic [NUM_CH-1:0] trans;
   logic              period_strobe;

   exp_t sb [$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_fail = 0;

   int   m_base;
   int   m_shadow [NUM_CH];
   int   m_active [NUM_CH];
   bit   m_err;
   bit   m_acc;

   trans_phase_driver #(
      .NUM_CH(NUM_CH),
      .PERIOD(PERIOD),
      .DUTY  (DUTY)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .out_en       (out_en),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_ch        (ld_ch),
      .ld_phase     (ld_phase),
      .ld_err       (ld_err),
      .trans        (trans),
      .period_strobe(period_strobe)
   );

   always #10 CLK = ~CLK;

   function automatic void chk(string nm, logic [63:0] act,
                               logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, req, $time);
      end
   endfunction

   always @(posedge CLK) begin
      #1;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         chk("trans", 64'(trans), 64'(mon_e.trans));
         chk("ctrl", {61'd0, period_strobe, ld_ready, ld_err},
             {61'd0, mon_e.strobe, mon_e.ready, mon_e.err});
      end
   end

   task automatic model_reset();
      m_base = 0;
      m_err  = 1'b0;
      m_acc  = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         m_shadow[i] = 0;
         m_active[i] = 0;
      end
   endtask

   // One clock: drive inputs, predict the state right after the next edge.
   task automatic step(bit v, logic [5:0] ch, logic [10:0] ph, bit en);
      exp_t t;
      bit   rdy;
      @(negedge CLK);
      ld_valid = v;
      ld_ch    = ch;
      ld_phase = ph;
      out_en   = en;
      rdy   = (m_base != PERIOD - 1);
      m_acc = v && rdy;
      for (int i = 0; i < NUM_CH; i++) begin
         t.trans[i] = en &&
            (((m_base - m_active[i] + PERIOD) % PERIOD) < DUTY);
      end
      if (m_base == PERIOD - 1) m_active = m_shadow;
      if (m_acc) begin
         if (int'(ch) < NUM_CH)
            m_shadow[ch] = (int'(ph) >= PERIOD) ? PERIOD - 1 : int'(ph);
         else
            m_err = 1'b1;
      end
      m_base   = (m_base + 1) % PERIOD;
      t.strobe = (m_base == PERIOD - 1);
      t.ready  = !t.strobe;
      t.err    = m_err;
      sb.push_back(t);
   endtask

   task automatic idle(int n);
      repeat (n) step(1'b0, 6'd0, 11'd0, 1'b1);
   endtask

   task automatic idle_until(int b);
      for (int k = 0; k < PERIOD && m_base != b; k++) idle(1);
   endtask

   task automatic load(logic [5:0] ch, logic [10:0] ph);
      for (int k = 0; k < 4; k++) begin
         step(1'b1, ch, ph, 1'b1);
         if (m_acc) break;
      end
   endtask

   task automatic check_reset_outs(string nm);
      chk({nm, "_trans"}, 64'(trans), 64'd0);
      chk({nm, "_ctrl"}, {61'd0, period_strobe, ld_ready, ld_err},
          64'b010);
   endtask

   task automatic do_reset(int cycles);
      @(negedge CLK);
      #3;
      RST_N    = 1'b0;
      ld_valid = 1'b0;
      #1;
      check_reset_outs("rst_async");
      repeat (cycles) @(negedge CLK);
      check_reset_outs("rst_hold");
      @(posedge CLK);
      #5;
      RST_N = 1'b1;
      model_reset();
   endtask

   task automatic random_run(int n);
      bit          v = 1'b0;
      bit          pend = 1'b0;
      bit          en = 1'b1;
      logic [5:0]  c = '0;
      logic [10:0] p = '0;
      repeat (n) begin
         if (!pend) begin
            v = ($urandom_range(0, 3) == 0);
            c = ($urandom_range(0, 9) == 0) ?
                6'($urandom_range(49, 63)) : 6'($urandom_range(0, 48));
            p = 11'($urandom_range(0, 2047));
         end
         if ($urandom_range(0, 399) == 0) en = !en;
         step(v, c, p, en);
         pend = v && !m_acc;
      end
   endtask

   initial begin
      model_reset();
      #5;
      check_reset_outs("rst_init");
      @(posedge CLK);
      #5;
      RST_N = 1'b1;

      idle(2 * PERIOD + 5);

      idle_until(400);
      load(6'd3, 11'd100);
      idle(2 * PERIOD);

      idle_until(PERIOD - 1);
      load(6'd7, 11'd300);
      idle(2);
      load(6'd7, 11'd10);
      load(6'd7, 11'd450);
      idle(PERIOD + 10);

      load(6'd60, 11'd5);
      load(6'd5, 11'd2000);
      idle(2 * PERIOD);

      random_run(6 * PERIOD);
      idle(PERIOD + 5);

      idle_until(500);
      load(6'd9, 11'd700);
      idle(3);
      do_reset(3);
      idle(2 * PERIOD + 5);

      repeat (3) @(posedge CLK);
      #2;
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
